// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: decode/EX/MEM hazard sources in, pipeline enables, bubbles and status out.
// The slave side is the hazard controller; the master side is the core datapath.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned STALL_CNT_W = 16
);
  logic [4:0]             id_rs;
  logic [4:0]             id_rt;
  logic                   id_use_rs;
  logic                   id_use_rt;
  logic                   ex_mem_read;
  logic [4:0]             ex_dst_reg;
  logic                   mem_redirect;
  logic                   mem_dmem_access;
  logic                   dmem_ready;
  logic                   imem_ready;

  logic                   pc_wren;
  logic                   fd_wren;
  logic                   de_wren;
  logic                   em_wren;
  logic                   mw_wren;
  logic                   fd_bubble;
  logic                   de_bubble;
  logic                   em_bubble;
  logic                   mw_bubble;
  logic [1:0]             state;
  logic [STALL_CNT_W-1:0] stall_cycles;
  logic                   dmem_timeout;

  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_dst_reg,
           mem_redirect, mem_dmem_access, dmem_ready, imem_ready,
    input  pc_wren, fd_wren, de_wren, em_wren, mw_wren,
           fd_bubble, de_bubble, em_bubble, mw_bubble,
           state, stall_cycles, dmem_timeout
  );

  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_mem_read, ex_dst_reg,
           mem_redirect, mem_dmem_access, dmem_ready, imem_ready,
    output pc_wren, fd_wren, de_wren, em_wren, mw_wren,
           fd_bubble, de_bubble, em_bubble, mw_bubble,
           state, stall_cycles, dmem_timeout
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer of the 5-stage pipeline: stage write enables, NOP bubble selects,
// data-memory wait tracking with timeout halt, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT     = 64,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  pipeline_hazard_ctrl_if.slave       bus
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;

  localparam int unsigned            WAIT_W    = 16;
  localparam logic [WAIT_W-1:0]      WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic [WAIT_W-1:0]      w_next_wait_cnt;
  logic [STALL_CNT_W-1:0] r_stall_cycles;
  logic                   r_dmem_timeout;
  logic                   w_set_timeout;
  logic                   w_load_use;
  logic                   w_dmem_stall;

  logic w_pc_wren, w_fd_wren, w_de_wren, w_em_wren, w_mw_wren;
  logic w_fd_bubble, w_de_bubble, w_em_bubble, w_mw_bubble;

  // r0 is hardwired zero, so a load targeting it never creates a dependency
  always_comb begin
    w_load_use = bus.ex_mem_read && (bus.ex_dst_reg != 5'd0) &&
                 ((bus.id_use_rs && (bus.id_rs == bus.ex_dst_reg)) ||
                  (bus.id_use_rt && (bus.id_rt == bus.ex_dst_reg)));
  end

  // Next-state, wait counter and pipeline control
  always_comb begin
    w_next_state    = r_state;
    w_next_wait_cnt = r_wait_cnt;
    w_set_timeout   = 1'b0;
    w_dmem_stall    = 1'b0;
    w_pc_wren       = 1'b1;
    w_fd_wren       = 1'b1;
    w_de_wren       = 1'b1;
    w_em_wren       = 1'b1;
    w_mw_wren       = 1'b1;
    w_fd_bubble     = 1'b0;
    w_de_bubble     = 1'b0;
    w_em_bubble     = 1'b0;
    w_mw_bubble     = 1'b0;

    case (r_state)
      ST_RUN: begin
        if (bus.mem_dmem_access && !bus.dmem_ready) begin
          w_dmem_stall    = 1'b1;
          w_next_state    = ST_MEM_WAIT;
          w_next_wait_cnt = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (!bus.dmem_ready) begin
          w_dmem_stall = 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_next_state  = ST_HALT;
            w_set_timeout = 1'b1;
          end else begin
            w_next_wait_cnt = r_wait_cnt + WAIT_W'(1);
          end
        end else begin
          w_next_state    = ST_RUN;
          w_next_wait_cnt = '0;
        end
      end
      ST_HALT: begin
        w_pc_wren = 1'b0;
        w_fd_wren = 1'b0;
        w_de_wren = 1'b0;
        w_em_wren = 1'b0;
        w_mw_wren = 1'b0;
      end
      default: begin
        w_next_state    = ST_RUN;
        w_next_wait_cnt = '0;
      end
    endcase

    // Hazard priority: dmem wait freezes up to EM, redirect squashes the three younger stages
    if (r_state != ST_HALT) begin
      if (w_dmem_stall) begin
        w_pc_wren   = 1'b0;
        w_fd_wren   = 1'b0;
        w_de_wren   = 1'b0;
        w_em_wren   = 1'b0;
        w_mw_bubble = 1'b1;
      end else if (bus.mem_redirect) begin
        w_fd_bubble = 1'b1;
        w_de_bubble = 1'b1;
        w_em_bubble = 1'b1;
      end else if (w_load_use) begin
        w_pc_wren   = 1'b0;
        w_fd_wren   = 1'b0;
        w_de_bubble = 1'b1;
      end else if (!bus.imem_ready) begin
        w_pc_wren   = 1'b0;
        w_fd_bubble = 1'b1;
      end
    end
  end

  // State, wait counter, stall counter and sticky timeout
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_stall_cycles <= '0;
      r_dmem_timeout <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait_cnt;
      if ((r_state != ST_HALT) && !w_pc_wren && (r_stall_cycles != STALL_MAX)) begin
        r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
      end
      if (w_set_timeout) begin
        r_dmem_timeout <= 1'b1;
      end
    end
  end

  assign bus.pc_wren      = w_pc_wren;
  assign bus.fd_wren      = w_fd_wren;
  assign bus.de_wren      = w_de_wren;
  assign bus.em_wren      = w_em_wren;
  assign bus.mw_wren      = w_mw_wren;
  assign bus.fd_bubble    = w_fd_bubble;
  assign bus.de_bubble    = w_de_bubble;
  assign bus.em_bubble    = w_em_bubble;
  assign bus.mw_bubble    = w_mw_bubble;
  assign bus.state        = r_state;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.dmem_timeout = r_dmem_timeout;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed hazard scenarios then random traffic,
// all checked against a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TIMEOUT     = 4;
  localparam int unsigned STALL_CNT_W = 4;
  localparam int          STALL_SAT   = 15;

  localparam int K_NONE  = 0;
  localparam int K_IMEM  = 1;
  localparam int K_LU    = 2;
  localparam int K_REDIR = 3;
  localparam int K_DMEM  = 4;
  localparam int K_HALT  = 5;

  logic clk = 1'b0;
  logic reset_n;

  int checks = 0;
  int errors = 0;

  // Model: mode 0=running, 1=waiting on dmem, 2=halted
  int m_mode  = 0;
  int m_wait  = 0;
  int m_stall = 0;
  int m_to    = 0;

  pipeline_hazard_ctrl_if #(.STALL_CNT_W(STALL_CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .TIMEOUT     (TIMEOUT),
    .STALL_CNT_W (STALL_CNT_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of run, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int rs, input int rt, input bit use_rs, input bit use_rt,
                        input bit exr, input int dst, input bit redir, input bit acc,
                        input bit dready, input bit iready);
    bus.id_rs           = 5'(rs);
    bus.id_rt           = 5'(rt);
    bus.id_use_rs       = use_rs;
    bus.id_use_rt       = use_rt;
    bus.ex_mem_read     = exr;
    bus.ex_dst_reg      = 5'(dst);
    bus.mem_redirect    = redir;
    bus.mem_dmem_access = acc;
    bus.dmem_ready      = dready;
    bus.imem_ready      = iready;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
  endtask

  function automatic int classify();
    bit dmem_wait;
    bit lu;
    if (m_mode == 2) return K_HALT;
    dmem_wait = (m_mode == 0) ? (bus.mem_dmem_access && !bus.dmem_ready) : !bus.dmem_ready;
    lu = bus.ex_mem_read && (bus.ex_dst_reg != 0) &&
         ((bus.id_use_rs && bus.id_rs == bus.ex_dst_reg) ||
          (bus.id_use_rt && bus.id_rt == bus.ex_dst_reg));
    if (dmem_wait) return K_DMEM;
    if (bus.mem_redirect) return K_REDIR;
    if (lu) return K_LU;
    if (!bus.imem_ready) return K_IMEM;
    return K_NONE;
  endfunction

  // {pc,fd,de,em,mw wren, fd,de,em,mw bubble} for each hazard class
  function automatic logic [8:0] ctl_of(input int kind);
    case (kind)
      K_HALT:  return 9'b00000_0000;
      K_DMEM:  return 9'b00001_0001;
      K_REDIR: return 9'b11111_1110;
      K_LU:    return 9'b00111_0100;
      K_IMEM:  return 9'b01111_1000;
      default: return 9'b11111_0000;
    endcase
  endfunction

  // Check one cycle (inputs already driven after a negedge), then advance the model across posedge
  task automatic cycle(input string tag);
    int kind;
    logic [8:0] obs_ctl;
    #1;
    kind = classify();
    obs_ctl = {bus.pc_wren, bus.fd_wren, bus.de_wren, bus.em_wren, bus.mw_wren,
               bus.fd_bubble, bus.de_bubble, bus.em_bubble, bus.mw_bubble};
    if (reset_n) check({tag, "_ctl"}, 32'(obs_ctl), 32'(ctl_of(kind)));
    check({tag, "_state"}, 32'(bus.state), 32'(m_mode));
    check({tag, "_stall"}, 32'(bus.stall_cycles), 32'(m_stall));
    check({tag, "_tout"}, 32'(bus.dmem_timeout), 32'(m_to));
    if (!reset_n) begin
      m_mode = 0; m_wait = 0; m_stall = 0; m_to = 0;
    end else begin
      if (kind == K_DMEM || kind == K_LU || kind == K_IMEM)
        m_stall = (m_stall + 1 > STALL_SAT) ? STALL_SAT : m_stall + 1;
      if (m_mode == 0 && kind == K_DMEM) begin
        m_mode = 1; m_wait = 1;
      end else if (m_mode == 1) begin
        if (bus.dmem_ready) begin
          m_mode = 0; m_wait = 0;
        end else if (m_wait == int'(TIMEOUT) - 1) begin
          m_mode = 2; m_to = 1;
        end else begin
          m_wait++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    idle();
    cycle("rst");
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    idle();
    @(negedge clk);
    cycle("rst0");
    cycle("rst1");
    reset_n = 1'b1;
    #1;
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_stall", 32'(bus.stall_cycles), 32'd0);
    check("reset_tout", 32'(bus.dmem_timeout), 32'd0);
    @(negedge clk);

    // Load-use on rs, then load leaves EX
    set_in(5, 0, 1, 0, 1, 5, 0, 0, 1, 1);
    #1;
    check("lu_pc_wren", 32'(bus.pc_wren), 32'd0);
    check("lu_de_bubble", 32'(bus.de_bubble), 32'd1);
    cycle("lu");
    idle();
    cycle("lu_after");
    check("lu_stall_count", 32'(bus.stall_cycles), 32'd1);
    // Load to r0 is not a hazard; matching rs and rt still one stall
    set_in(0, 0, 1, 1, 1, 0, 0, 0, 1, 1);
    cycle("lu_r0");
    set_in(7, 7, 1, 1, 1, 7, 0, 0, 1, 1);
    cycle("lu_both");
    idle();
    cycle("lu_both_after");
    check("lu_both_stall", 32'(bus.stall_cycles), 32'd2);

    // Redirect overrides load-use and imem wait
    reset_pulse();
    set_in(5, 0, 1, 0, 1, 5, 1, 0, 1, 0);
    #1;
    check("redir_mw_bubble", 32'(bus.mw_bubble), 32'd0);
    check("redir_em_bubble", 32'(bus.em_bubble), 32'd1);
    cycle("redir");
    idle();
    cycle("redir_after");
    check("redir_stall", 32'(bus.stall_cycles), 32'd0);

    // Dmem wait three cycles then release
    reset_pulse();
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      cycle("dwait");
    end
    check("dwait_state", 32'(bus.state), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    #1;
    check("dwait_release_pc", 32'(bus.pc_wren), 32'd1);
    cycle("dwait_rel");
    idle();
    cycle("dwait_after");
    check("dwait_state_run", 32'(bus.state), 32'd0);
    check("dwait_stall", 32'(bus.stall_cycles), 32'd3);

    // Timeout halts; ready afterwards has no effect; reset recovers
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      cycle("tout");
    end
    check("tout_state", 32'(bus.state), 32'd2);
    check("tout_flag", 32'(bus.dmem_timeout), 32'd1);
    set_in(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    cycle("halt_ready");
    check("halt_state", 32'(bus.state), 32'd2);
    check("halt_stall", 32'(bus.stall_cycles), 32'd4);
    reset_pulse();
    idle();
    cycle("post_halt");
    check("recover_state", 32'(bus.state), 32'd0);
    check("recover_tout", 32'(bus.dmem_timeout), 32'd0);

    // Imem wait two cycles
    reset_pulse();
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle("imem");
    end
    check("imem_stall", 32'(bus.stall_cycles), 32'd2);

    // Saturation after 20 imem-wait cycles
    reset_pulse();
    for (int i = 0; i < 20; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      cycle("sat");
    end
    check("sat_stall", 32'(bus.stall_cycles), 32'd15);

    // Reset mid-wait clears everything
    reset_pulse();
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    cycle("midwait");
    reset_pulse();
    idle();
    cycle("midwait_after");
    check("midwait_state", 32'(bus.state), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 800; n++) begin
      reset_n = ($urandom_range(0, 40) != 0);
      set_in(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), bit'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0));
      cycle("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencing unit for the 5-stage pipeline. Drives the write enables of the PC and the four stage registers (FD, DE, EM, MW), plus per-stage bubble selects.
- Resolves load-use hazards, control redirects resolved in MEM, instruction-memory wait and data-memory wait. Halts the core on a data-memory timeout.
- Bubble selects are consumed at top level. Each one forces zero into the control inputs of the named stage register for that write, which inserts a NOP.

Parameters:
- TIMEOUT, 64: max consecutive MEM_WAIT cycles before halt. Legal range 2..65535.
- STALL_CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- id_rs  in  5  rs field of the instruction in ID (FD register output)
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  DE register dec_mem_read (load in EX)
- ex_dst_reg  in  5  DE register dst_reg
- mem_redirect  in  1  EM-stage branch taken, jump, or ALU-result-to-PC; PC source switches to target
- mem_dmem_access  in  1  EM-stage dec_mem_read or dec_mem_write
- dmem_ready  in  1  data memory completes the access this cycle
- imem_ready  in  1  instruction memory returns a valid word this cycle
- pc_wren  out  1  PC write enable
- fd_wren, de_wren, em_wren, mw_wren  out  1 each  stage register write enables
- fd_bubble, de_bubble, em_bubble, mw_bubble  out  1 each  zero control inputs of that stage on this write
- state  out  2  0=RUN, 1=MEM_WAIT, 2=HALT
- stall_cycles  out  STALL_CNT_W  saturating count of cycles with pc_wren=0 while not in HALT
- dmem_timeout  out  1  sticky timeout flag

Behaviour:
- Reset: clk edge with reset_n=0.
  - state=RUN, stall_cycles=0, dmem_timeout=0, wait counter=0.
  - All enable/bubble outputs are combinational from state and inputs. They are don't-care during reset because the stage registers self-clear.
- Default (RUN, no hazard): all wren=1, all bubble=0.
- Priority in RUN, highest first:
  1. Dmem wait (mem_dmem_access & !dmem_ready):
     - pc/fd/de/em_wren=0; mw_wren=1, mw_bubble=1.
     - Next state MEM_WAIT, wait counter=1.
  2. Redirect (mem_redirect):
     - All wren=1; fd_bubble=de_bubble=em_bubble=1. This squashes the 3 younger instructions.
     - A load-use condition or imem_ready=0 in the same cycle is ignored.
  3. Load-use:
     - Condition: ex_mem_read & ex_dst_reg!=0 & ((id_use_rs & id_rs==ex_dst_reg) | (id_use_rt & id_rt==ex_dst_reg)).
     - pc_wren=0, fd_wren=0, de_bubble=1; DE/EM/MW advance. Exactly one stall cycle per load.
  4. Imem wait (!imem_ready): pc_wren=0, fd_bubble=1; the rest advance.
- MEM_WAIT:
  - While dmem_ready=0: same outputs as case 1; wait counter increments.
  - dmem_ready=1: outputs follow the RUN priority list with case 1 treated as false. Next state RUN, counter cleared.
  - dmem_ready=0 with counter==TIMEOUT-1 on that edge: next state HALT, dmem_timeout=1.
- HALT: all wren=0, all bubble=0. Leaves HALT only on reset. stall_cycles frozen.
- stall_cycles: +1 on each clk edge where state!=HALT, pc_wren=0 and reset_n=1. Saturates at all-ones, no wrap.
- Register 0 is never a load-use hazard. Matching both rs and rt still yields one stall cycle.
- Reset asserted mid-stall or mid-wait returns immediately to RUN with cleared counters. No pending hazard survives reset.

Test Plan:
- Load-use: `lw r5` in EX (ex_mem_read=1, ex_dst_reg=5) and `add` in ID with id_rs=5, id_use_rs=1 -> one cycle of pc_wren=fd_wren=0, de_bubble=1, then all wren=1; stall_cycles=1. Repeat with ex_dst_reg=0 -> no stall.
- Redirect: mem_redirect=1 pulsed for 1 cycle, together with a load-use match and imem_ready=0 -> all wren=1, fd/de/em_bubble=1, mw_bubble=0; stall_cycles unchanged.
- Dmem wait: mem_dmem_access=1, dmem_ready low for 3 cycles then high -> 3 cycles of pc/fd/de/em_wren=0 with mw_bubble=1, state=1. Release cycle has all wren=1 and state returns to 0; stall_cycles=3.
- Timeout (TIMEOUT=4): dmem_ready held 0 -> state=2 after 4 cycles, dmem_timeout=1, all wren=0. Asserting dmem_ready afterwards has no effect; reset_n=0 then 1 gives state=0, dmem_timeout=0.
- Imem wait: imem_ready=0 for 2 cycles -> pc_wren=0, fd_bubble=1, de/em/mw_wren=1 in both cycles; stall_cycles=2.
- Saturation (STALL_CNT_W=4): 20 imem-wait cycles -> stall_cycles=15.
